// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - single-master CPU to MMIO-page bridge with claim/done handshake
// Optional access timeout enabled by defining MMIO_BRIDGE_TIMEOUT_EN.
module mmio_bridge #(
    parameter int N_SLAVES       = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_write,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic                  cpu_resp_err,
    output logic [31:0]           cpu_rdata,
    output logic                  mmio_read,
    output logic                  mmio_write,
    output logic [31:0]           mmio_addr,
    output logic [31:0]           mmio_write_data,
    input  logic [N_SLAVES-1:0]   slave_work,
    input  logic [N_SLAVES-1:0]   slave_done,
    input  logic [32*N_SLAVES-1:0] slave_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [N_SLAVES-1:0] ONE = 1;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        one_hot;
    logic        claim_done;
    logic        timed_out;
    logic [31:0] sel_rdata;

    // Exactly one claimant; done from anyone else is masked off by the claim vector.
    assign one_hot    = (slave_work != '0) && ((slave_work & (slave_work - ONE)) == '0);
    assign claim_done = |(slave_work & slave_done);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (slave_work[i]) begin
                sel_rdata = sel_rdata | slave_rdata[32*i +: 32];
            end
        end
    end

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (!rst_n || state_q != ACCESS) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end

    assign timed_out = (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    if (cpu_addr[31:16] == 16'hFFFF) begin
                        wr_d    = cpu_req_write;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (!one_hot) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (claim_done) begin
                    err_d   = 1'b0;
                    rdata_d = wr_q ? 32'd0 : sel_rdata;
                    state_d = RESP;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes exist only in ACCESS so a slave sees them fall in RESP and can re-arm.
    assign cpu_req_ready   = (state_q == IDLE);
    assign cpu_resp_valid  = (state_q == RESP);
    assign cpu_resp_err    = (state_q == RESP) && err_q;
    assign cpu_rdata       = rdata_q;
    assign mmio_read       = (state_q == ACCESS) && !wr_q;
    assign mmio_write      = (state_q == ACCESS) && wr_q;
    assign mmio_addr       = addr_q;
    assign mmio_write_data = wdata_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - directed self-checking bench for mmio_bridge
module tb_mmio_bridge;

    localparam int N = 4;

    logic            sys_clk = 1'b0;
    logic            rst_n   = 1'b0;
    logic            cpu_req_valid = 1'b0;
    logic            cpu_req_ready;
    logic            cpu_req_write = 1'b0;
    logic [31:0]     cpu_addr  = '0;
    logic [31:0]     cpu_wdata = '0;
    logic            cpu_resp_valid;
    logic            cpu_resp_err;
    logic [31:0]     cpu_rdata;
    logic            mmio_read;
    logic            mmio_write;
    logic [31:0]     mmio_addr;
    logic [31:0]     mmio_write_data;
    logic [N-1:0]    slave_work;
    logic [N-1:0]    slave_done;
    logic [32*N-1:0] slave_rdata;

    logic [N-1:0]    claim   = '0;
    logic [N-1:0]    done_en = '0;
    logic [N-1:0]    served;
    logic [31:0]     srd [N];
    int              done_cnt = 0;
    int              passed = 0;
    int              total  = 0;

    always #5 sys_clk = ~sys_clk;

    mmio_bridge #(.N_SLAVES(N), .TIMEOUT_CYCLES(16)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_write(cpu_req_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_err(cpu_resp_err), .cpu_rdata(cpu_rdata),
        .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_addr(mmio_addr), .mmio_write_data(mmio_write_data),
        .slave_work(slave_work), .slave_done(slave_done), .slave_rdata(slave_rdata)
    );

    // Slave models: combinational claim, one registered done pulse per access.
    assign slave_work = claim & {N{mmio_read | mmio_write}};

    always_comb begin
        slave_rdata = '0;
        for (int i = 0; i < N; i++) slave_rdata[32*i +: 32] = srd[i];
    end

    always @(posedge sys_clk) begin
        if (!rst_n) begin
            slave_done <= '0;
            served     <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                slave_done[i] <= (mmio_read | mmio_write) & claim[i] & done_en[i]
                                 & !served[i] & !slave_done[i];
                served[i]     <= (mmio_read | mmio_write) ? (served[i] | slave_done[i]) : 1'b0;
            end
            if (|slave_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Presents one request in cycle 0; returns positioned in cycle 1.
    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
        cpu_req_valid = 1'b1;
        cpu_req_write = w;
        cpu_addr      = a;
        cpu_wdata     = d;
        tick();
        cpu_req_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int resp_cyc;
        logic resp_err;
        for (int i = 0; i < N; i++) srd[i] = 32'h0;

        tick(); tick();
        chk("rst_ready", cpu_req_ready, 1);
        chk("rst_resp_valid", cpu_resp_valid, 0);
        chk("rst_resp_err", cpu_resp_err, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_strobes", {mmio_read, mmio_write}, 0);
        chk("rst_addr", mmio_addr, 0);
        chk("rst_wdata", mmio_write_data, 0);
        rst_n = 1'b1;
        tick();

        // Load served by slave 1
        srd[1] = 32'h0000_00A5; srd[2] = 32'hDEAD_BEEF;
        claim = 4'b0010; done_en = 4'b1111;
        req(1'b0, 32'hFFFF_0140, 32'h0);
        chk("ld_c1_read", mmio_read, 1);
        chk("ld_c1_addr", mmio_addr, 32'hFFFF_0140);
        chk("ld_c1_ready", cpu_req_ready, 0);
        chk("ld_c1_resp", cpu_resp_valid, 0);
        tick();
        chk("ld_c2_read", mmio_read, 1);
        chk("ld_c2_resp", cpu_resp_valid, 0);
        tick();
        chk("ld_c3_resp", cpu_resp_valid, 1);
        chk("ld_c3_err", cpu_resp_err, 0);
        chk("ld_c3_rdata", cpu_rdata, 32'hA5);
        chk("ld_c3_read", mmio_read, 0);
        tick();
        chk("ld_c4_resp", cpu_resp_valid, 0);
        chk("ld_c4_ready", cpu_req_ready, 1);
        chk("ld_c4_rdata_hold", cpu_rdata, 32'hA5);

        // Out-of-page load
        claim = 4'b0000;
        req(1'b0, 32'h8000_0000, 32'h0);
        chk("oop_c1_resp", cpu_resp_valid, 1);
        chk("oop_c1_err", cpu_resp_err, 1);
        chk("oop_c1_rdata", cpu_rdata, 0);
        chk("oop_c1_read", mmio_read, 0);
        tick();

        // Store served by slave 2
        claim = 4'b0100;
        d0 = done_cnt;
        req(1'b1, 32'hFFFF_0148, 32'h0000_1234);
        chk("st_c1_write", mmio_write, 1);
        chk("st_c1_read", mmio_read, 0);
        chk("st_c1_wdata", mmio_write_data, 32'h1234);
        tick();
        chk("st_c2_wdata", mmio_write_data, 32'h1234);
        chk("st_c2_write", mmio_write, 1);
        tick();
        chk("st_c3_resp", cpu_resp_valid, 1);
        chk("st_c3_err", cpu_resp_err, 0);
        chk("st_c3_rdata", cpu_rdata, 0);
        chk("st_c3_write", mmio_write, 0);
        tick(); tick();
        chk("st_done_pulses", done_cnt - d0, 1);

        // Unclaimed in-page load
        claim = 4'b0000;
        req(1'b0, 32'hFFFF_0900, 32'h0);
        chk("unc_c1_read", mmio_read, 1);
        chk("unc_c1_resp", cpu_resp_valid, 0);
        tick();
        chk("unc_c2_resp", cpu_resp_valid, 1);
        chk("unc_c2_err", cpu_resp_err, 1);
        chk("unc_c2_rdata", cpu_rdata, 0);
        tick();

        // Two claimants
        claim = 4'b0101; srd[0] = 32'h11;
        req(1'b0, 32'hFFFF_0200, 32'h0);
        chk("mc_c1_read", mmio_read, 1);
        tick();
        chk("mc_c2_resp", cpu_resp_valid, 1);
        chk("mc_c2_err", cpu_resp_err, 1);
        chk("mc_c2_strobes", {mmio_read, mmio_write}, 0);
        tick();

        // Claim vanishes before done
        claim = 4'b0010; done_en = 4'b0000;
        req(1'b0, 32'hFFFF_0300, 32'h0);
        tick();
        chk("drop_c2_resp", cpu_resp_valid, 0);
        claim = 4'b0000;
        tick();
        chk("drop_c3_resp", cpu_resp_valid, 1);
        chk("drop_c3_err", cpu_resp_err, 1);
        tick();

        // Claimed but never done
        claim = 4'b1000; done_en = 4'b0000;
        resp_cyc = 0; resp_err = 1'b0;
        req(1'b0, 32'hFFFF_0400, 32'h0);
        for (int c = 1; c <= 100; c++) begin
            if (cpu_resp_valid && resp_cyc == 0) begin
                resp_cyc = c;
                resp_err = cpu_resp_err;
            end
            tick();
        end
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        chk("to_resp_cycle", resp_cyc, 17);
        chk("to_resp_err", resp_err, 1);
        chk("to_rdata", cpu_rdata, 0);
`else
        chk("noto_no_resp", resp_cyc, 0);
        chk("noto_still_read", mmio_read, 1);
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in cycle 2 of an access
        claim = 4'b0010; done_en = 4'b1111;
        req(1'b0, 32'hFFFF_0140, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rmid_strobes", {mmio_read, mmio_write}, 0);
        chk("rmid_resp", cpu_resp_valid, 0);
        chk("rmid_ready", cpu_req_ready, 1);
        rst_n = 1'b1;
        tick();
        chk("rmid_after_resp", cpu_resp_valid, 0);

        // Recovery load from slave 0
        claim = 4'b0001; srd[0] = 32'h0000_005A;
        req(1'b0, 32'hFFFF_0010, 32'h0);
        tick(); tick();
        chk("rec_resp", cpu_resp_valid, 1);
        chk("rec_err", cpu_resp_err, 0);
        chk("rec_rdata", cpu_rdata, 32'h5A);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Single-master MMIO bridge between the CPU load/store path and the memory-mapped peripherals (timers, LEDs, UART) in the 0xFFFF_xxxx page. It accepts one CPU access at a time and broadcasts `mmio_read`/`mmio_write`/address/data to all slaves. It collects each slave's `mmio_work` claim, `mmio_done` and read data, then returns a single-cycle response, with an error for unclaimed, multiply-claimed or (optionally) timed-out accesses.

## Interface
- `N_SLAVES`, 4: number of attached peripherals.
- `TIMEOUT_CYCLES`, 16: max cycles between claim and `mmio_done`; used only with `MMIO_BRIDGE_TIMEOUT_EN`.
- `sys_clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `cpu_req_valid` in 1: CPU access request.
- `cpu_req_ready` out 1: high only in IDLE; transfer on valid && ready.
- `cpu_req_write` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data.
- `cpu_resp_valid` out 1: one-cycle response strobe.
- `cpu_resp_err` out 1: response is an error; qualified by `cpu_resp_valid`.
- `cpu_rdata` out 32: load data; qualified by `cpu_resp_valid`.
- `mmio_read` / `mmio_write` out 1: broadcast strobes to slaves.
- `mmio_addr` / `mmio_write_data` out 32: broadcast address/data, held for the whole access.
- `slave_work` in N_SLAVES: per-slave combinational claim.
- `slave_done` in N_SLAVES: per-slave registered completion.
- `slave_rdata` in 32*N_SLAVES: slave i at bits [32i+31:32i], valid while that slave claims.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `cpu_req_ready`=1. A transfer with `cpu_addr[31:16]`==16'hFFFF latches addr/wdata/write and moves to ACCESS.
  - A transfer outside the page is consumed and returns RESP with err=1, rdata=0.
- ACCESS:
  - `mmio_read` = !write, `mmio_write` = write; addr/data come from the latches.
  - The claim vector is `slave_work`:
    - Zero bits set: go to RESP, err=1.
    - More than one bit set: go to RESP, err=1. Strobes still drop on exit.
    - Exactly one bit set: wait for that slave's `slave_done`. Done bits from unclaimed slaves are ignored.
  - On the claimed slave's done: capture its `slave_rdata` (zero for stores), go to RESP with err=0.
- RESP:
  - `cpu_resp_valid`=1 and the strobes are low; the next state is IDLE.
  - The strobes must drop here, or the slave re-arms and toggles `mmio_done`.
- `cpu_rdata` holds its value until the next RESP. `cpu_resp_err` and `cpu_resp_valid` are 0 outside RESP.
- Reset values: state IDLE, `cpu_req_ready`=1, every other output 0, latches 0.

## Timing
- Normal access: accept at cycle 0; cycle 1 ACCESS (strobe high, slave claims); cycle 2 slave done, data captured; cycle 3 RESP. Total latency is 3 cycles from accept to `cpu_resp_valid`.
- Unclaimed access: RESP at cycle 2.
- Out-of-page access: RESP at cycle 1.
- Slow slaves are supported: ACCESS holds indefinitely until done, unless the timeout is enabled.
- A claim that disappears mid-ACCESS (`slave_work` goes to 0 before done) ends with err=1 on the next cycle.
- Reset mid-access: IDLE on the next edge, strobes low, no response issued. A stale `slave_done` seen in IDLE is ignored.
- Back-to-back: the next transfer can be accepted in the cycle after RESP, so the minimum spacing is 4 cycles.

## Configuration
- `MMIO_BRIDGE_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - At `TIMEOUT_CYCLES` without done, go to RESP with err=1 and rdata=0.
- Not defined: no counter; ACCESS waits for done forever.

## Test plan
- Load 0xFFFF0140 with slave 1 claiming and rdata=0x0000_00A5: strobe high cycles 1–2, low in cycle 3; resp at cycle 3 with err=0, rdata=0xA5.
- Store 0xFFFF0148, wdata 0x1234: `mmio_write_data`=0x1234 held in cycles 1–2; slave done pulses once; resp err=0.
- Load 0xFFFF0900 with no claim: resp at cycle 2 with err=1, rdata=0. Load 0x8000_0000: resp at cycle 1 with err=1.
- Slaves 0 and 2 both claim: resp err=1, and both strobes are low on the resp cycle.
- With `MMIO_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, slave claims but never completes: resp err=1 exactly 16 cycles after entering ACCESS. Without the macro: no resp after 100 cycles.
- `rst_n`=0 in cycle 2 of an access: state IDLE next cycle, strobes 0, no `cpu_resp_valid`, `cpu_req_ready`=1.
